// File: rtl/step_sequencer_core.sv
// Multi-channel step sequencer core: pattern store, tempo divider, step
// pointer, per-voice gating and per-voice square-wave tone generators.
// Outputs are registered and drive speaker pins / status LEDs directly.
module step_sequencer_core #(
  parameter int CHANNELS = 4,
  parameter int STEPS    = 16,
  parameter int TEMPO_W  = 28,
  parameter int HALF_W   = 16,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int ST_W     = $clog2(STEPS)
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       stop,
  input  logic [TEMPO_W-1:0]         tempo_div,
  input  logic [CHANNELS*HALF_W-1:0] half_period,
  input  logic                       wr_en,
  input  logic [CH_W-1:0]            wr_ch,
  input  logic [STEPS-1:0]           wr_pattern,
  input  logic                       tg_en,
  input  logic [CH_W-1:0]            tg_ch,
  input  logic [ST_W-1:0]            tg_step,
  input  logic [CH_W-1:0]            rd_ch,
  output logic [STEPS-1:0]           rd_pattern,
  output logic [ST_W-1:0]            step_idx,
  output logic                       step_tick,
  output logic [CHANNELS-1:0]        active,
  output logic [CHANNELS-1:0]        tone_out,
  output logic                       playing
);

  typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_HOLD} state_t;

  state_t               r_state;
  logic                 r_playing;
  logic                 r_step_tick;
  logic [ST_W-1:0]      r_step_idx;
  logic [TEMPO_W-1:0]   r_tempo_cnt;
  logic [STEPS-1:0]     r_pattern     [CHANNELS];
  logic [STEPS-1:0]     w_pattern_nxt [CHANNELS];
  logic [STEPS-1:0]     r_rd_pattern;
  logic [CHANNELS-1:0]  r_active;
  logic [CHANNELS-1:0]  w_active_nxt;
  logic [CHANNELS-1:0]  r_tone;
  logic [HALF_W-1:0]    r_tone_cnt    [CHANNELS];
  logic [HALF_W-1:0]    w_half        [CHANNELS];
  logic [TEMPO_W-1:0]   w_div_eff;
  logic                 w_term;
  logic                 w_adv;
  logic                 w_play_nxt;
  logic [ST_W-1:0]      w_step_nxt;

  // Tempo compare and next step pointer; the next state is PLAY exactly when run && !stop.
  always_comb begin
    w_div_eff  = (tempo_div < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo_div;
    w_term     = (r_tempo_cnt >= (w_div_eff - TEMPO_W'(1)));
    w_adv      = (r_state == ST_PLAY) && !stop && w_term;
    w_play_nxt = run && !stop;
    if (stop)       w_step_nxt = '0;
    else if (w_adv) w_step_nxt = r_step_idx + ST_W'(1);
    else            w_step_nxt = r_step_idx;
  end

  // Pattern edits for this cycle: full-row write beats a toggle on the same row.
  always_comb begin
    // NOTE: start from the current contents so every path assigns and no latch is inferred.
    w_pattern_nxt = r_pattern;
    if (wr_en && (int'(wr_ch) < CHANNELS))
      w_pattern_nxt[wr_ch] = wr_pattern;
    if (tg_en && (int'(tg_ch) < CHANNELS) && !(wr_en && (wr_ch == tg_ch)))
      w_pattern_nxt[tg_ch][tg_step] = ~r_pattern[tg_ch][tg_step];
  end

  // Per-channel gating from next-cycle state, so active always matches step_idx/playing.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_half[c]       = half_period[c*HALF_W +: HALF_W];
      w_active_nxt[c] = w_play_nxt & w_pattern_nxt[c][w_step_nxt];
    end
  end

  // Transport FSM with tempo counter, step pointer and registered status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= ST_STOP;
      r_playing   <= 1'b0;
      r_step_tick <= 1'b0;
      r_step_idx  <= '0;
      r_tempo_cnt <= '0;
    end else begin
      // NOTE: non-blocking so every register here samples the pre-edge values.
      r_step_tick <= w_adv;
      r_step_idx  <= w_step_nxt;
      if (stop) begin
        r_state     <= ST_STOP;
        r_playing   <= 1'b0;
        r_tempo_cnt <= '0;
      end else begin
        case (r_state)
          ST_STOP: if (run) begin
            r_state   <= ST_PLAY;
            r_playing <= 1'b1;
          end
          ST_PLAY: begin
            r_tempo_cnt <= w_term ? '0 : r_tempo_cnt + TEMPO_W'(1);
            if (!run) begin
              r_state   <= ST_HOLD;
              r_playing <= 1'b0;
            end
          end
          ST_HOLD: if (run) begin
            r_state   <= ST_PLAY;
            r_playing <= 1'b1;
          end
          default: begin
            r_state   <= ST_STOP;
            r_playing <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pattern store, registered readback and registered gating.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // NOTE: the pattern store is plain flops, so it is cleared on reset like any other state.
      for (int c = 0; c < CHANNELS; c++) r_pattern[c] <= '0;
      r_rd_pattern <= '0;
      r_active     <= '0;
    end else begin
      r_pattern    <= w_pattern_nxt;
      r_rd_pattern <= (int'(rd_ch) < CHANNELS) ? r_pattern[rd_ch] : '0;
      r_active     <= w_active_nxt;
    end
  end

  // Tone generators: run only while gated on across the edge, realign on every step advance.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) r_tone_cnt[c] <= '0;
      r_tone <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_adv || !r_active[c] || !w_active_nxt[c] || (w_half[c] == '0)) begin
          r_tone_cnt[c] <= '0;
          r_tone[c]     <= 1'b0;
        end else if (r_tone_cnt[c] >= (w_half[c] - HALF_W'(1))) begin
          r_tone_cnt[c] <= '0;
          r_tone[c]     <= ~r_tone[c];
        end else begin
          r_tone_cnt[c] <= r_tone_cnt[c] + HALF_W'(1);
        end
      end
    end
  end

  assign rd_pattern = r_rd_pattern;
  assign step_idx   = r_step_idx;
  assign step_tick  = r_step_tick;
  assign active     = r_active;
  assign tone_out   = r_tone;
  assign playing    = r_playing;

endmodule

// File: tb/tb_step_sequencer_core.sv
// Scoreboard bench for step_sequencer_core: a behavioural model predicts the
// outputs after every clock edge, a monitor pops and compares them.
module tb_step_sequencer_core;
  localparam int CH    = 3;
  localparam int STEPS = 4;
  localparam int TW    = 28;
  localparam int HW    = 16;
  localparam int CHW   = 2;
  localparam int STW   = 2;

  logic              CLOCK_50 = 1'b0;
  logic              reset, run, stop;
  logic [TW-1:0]     tempo_div;
  logic [CH*HW-1:0]  half_period;
  logic              wr_en, tg_en;
  logic [CHW-1:0]    wr_ch, tg_ch, rd_ch;
  logic [STEPS-1:0]  wr_pattern;
  logic [STW-1:0]    tg_step;
  logic [STEPS-1:0]  rd_pattern;
  logic [STW-1:0]    step_idx;
  logic              step_tick;
  logic [CH-1:0]     active;
  logic [CH-1:0]     tone_out;
  logic              playing;

  always #10 CLOCK_50 = ~CLOCK_50;

  step_sequencer_core #(
    .CHANNELS(CH), .STEPS(STEPS), .TEMPO_W(TW), .HALF_W(HW), .CH_W(CHW), .ST_W(STW)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .run(run), .stop(stop),
    .tempo_div(tempo_div), .half_period(half_period),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_pattern(wr_pattern),
    .tg_en(tg_en), .tg_ch(tg_ch), .tg_step(tg_step),
    .rd_ch(rd_ch), .rd_pattern(rd_pattern), .step_idx(step_idx),
    .step_tick(step_tick), .active(active), .tone_out(tone_out), .playing(playing)
  );

  typedef struct {
    logic [STW-1:0]   step;
    logic             tick;
    logic [CH-1:0]    active;
    logic [CH-1:0]    tone;
    logic             playing;
    logic [STEPS-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: mode 0 = stopped, 1 = playing, 2 = holding.
  logic [STEPS-1:0] m_pat [CH];
  int               m_mode, m_step, m_elapsed;
  logic [CH-1:0]    m_active;
  int               m_age [CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Predict the outputs after the coming edge from the current inputs, then clock once.
  task automatic step_cyc();
    exp_t             e;
    logic [STEPS-1:0] np [CH];
    logic [CH-1:0]    act_new;
    int               d, hp;
    bit               adv;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_pat[c] = '0;
        m_age[c] = 0;
      end
      m_mode = 0; m_step = 0; m_elapsed = 0; m_active = '0;
      e.step = '0; e.tick = 1'b0; e.active = '0; e.tone = '0; e.playing = 1'b0; e.rd = '0;
    end else begin
      e.rd = (int'(rd_ch) < CH) ? m_pat[int'(rd_ch)] : '0;
      for (int c = 0; c < CH; c++) np[c] = m_pat[c];
      if (wr_en && int'(wr_ch) < CH) np[int'(wr_ch)] = wr_pattern;
      if (tg_en && int'(tg_ch) < CH && !(wr_en && wr_ch == tg_ch))
        np[int'(tg_ch)][int'(tg_step)] = ~np[int'(tg_ch)][int'(tg_step)];
      d   = (int'(tempo_div) < 2) ? 2 : int'(tempo_div);
      adv = 1'b0;
      if (stop) begin
        m_mode = 0; m_step = 0; m_elapsed = 0;
      end else if (m_mode == 1) begin
        if (m_elapsed + 1 >= d) begin
          adv = 1'b1;
          m_elapsed = 0;
          m_step = (m_step + 1) % STEPS;
        end else begin
          m_elapsed++;
        end
        if (!run) m_mode = 2;
      end else if (run) begin
        m_mode = 1;
      end
      e.tone = '0;
      for (int c = 0; c < CH; c++) begin
        act_new[c] = (m_mode == 1) && np[c][m_step];
        hp = int'(half_period[c*HW +: HW]);
        if (!adv && m_active[c] && act_new[c] && hp != 0) begin
          m_age[c]++;
          e.tone[c] = ((m_age[c] / hp) % 2) == 1;
        end else begin
          m_age[c] = 0;
        end
      end
      for (int c = 0; c < CH; c++) m_pat[c] = np[c];
      m_active  = act_new;
      e.step    = STW'(m_step);
      e.tick    = adv;
      e.active  = act_new;
      e.playing = (m_mode == 1);
    end
    sb.push_back(e);
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cyc();
  endtask

  task automatic run_until_step(input int s);
    for (int i = 0; i < 400 && m_step != s; i++) step_cyc();
  endtask

  // Monitor: every edge produces an output set; compare it with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("step_idx",   64'(step_idx),   64'(e.step));
        check("step_tick",  64'(step_tick),  64'(e.tick));
        check("active",     64'(active),     64'(e.active));
        check("tone_out",   64'(tone_out),   64'(e.tone));
        check("playing",    64'(playing),    64'(e.playing));
        check("rd_pattern", 64'(rd_pattern), 64'(e.rd));
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized episodes.
  initial begin
    reset = 1'b1; run = 1'b0; stop = 1'b0; tempo_div = '0; half_period = '0;
    wr_en = 1'b0; wr_ch = '0; wr_pattern = '0; tg_en = 1'b0; tg_ch = '0; tg_step = '0; rd_ch = '0;
    m_mode = 0; m_step = 0; m_elapsed = 0; m_active = '0;
    for (int c = 0; c < CH; c++) begin
      m_pat[c] = '0;
      m_age[c] = 0;
    end

    idle(2);
    reset = 1'b0;

    // Basic play: ch0 = 0101, tempo 4.
    tempo_div = TW'(4);
    wr_en = 1'b1; wr_ch = 2'd0; wr_pattern = 4'b0101;
    step_cyc();
    wr_en = 1'b0;
    run = 1'b1;
    idle(20);

    // Tone: half period 3 on ch0, all steps on, tempo 20.
    stop = 1'b1; tempo_div = TW'(20);
    half_period = '0; half_period[0 +: HW] = HW'(3);
    wr_en = 1'b1; wr_ch = 2'd0; wr_pattern = 4'b1111;
    step_cyc();
    stop = 1'b0; wr_en = 1'b0;
    idle(50);

    // Hold at step 2 for 10 cycles, then resume.
    run_until_step(2);
    run = 1'b0;
    idle(10);
    run = 1'b1;
    idle(30);

    // Stop together with run at step 3.
    tempo_div = TW'(4);
    run_until_step(3);
    stop = 1'b1;
    step_cyc();
    stop = 1'b0;
    idle(5);

    // Same-cycle write and toggle on the same channel, then on different channels.
    rd_ch = 2'd1;
    wr_en = 1'b1; wr_ch = 2'd1; wr_pattern = 4'b1111;
    tg_en = 1'b1; tg_ch = 2'd1; tg_step = 2'd0;
    step_cyc();
    wr_en = 1'b0; tg_en = 1'b0;
    idle(2);
    rd_ch = 2'd2;
    wr_en = 1'b1; wr_ch = 2'd1; wr_pattern = 4'b1111;
    tg_en = 1'b1; tg_ch = 2'd2; tg_step = 2'd0;
    step_cyc();
    wr_en = 1'b0; tg_en = 1'b0;
    idle(2);

    // Out-of-range channel for write, toggle and readback.
    wr_en = 1'b1; wr_ch = 2'd3; wr_pattern = 4'b1111;
    tg_en = 1'b1; tg_ch = 2'd3; tg_step = 2'd1; rd_ch = 2'd3;
    step_cyc();
    wr_en = 1'b0; tg_en = 1'b0;
    idle(2);

    // Divisor clamp and zero half period, then reset mid-play.
    stop = 1'b1; tempo_div = '0; half_period = '0;
    step_cyc();
    stop = 1'b0;
    idle(12);
    reset = 1'b1;
    step_cyc();
    reset = 1'b0; rd_ch = 2'd0;
    idle(3);

    // Randomized episodes; half periods only change together with a stop.
    for (int ep = 0; ep < 25; ep++) begin
      stop = 1'b1; run = 1'b1;
      tempo_div = TW'($urandom_range(0, 6));
      for (int c = 0; c < CH; c++) half_period[c*HW +: HW] = HW'($urandom_range(0, 4));
      step_cyc();
      stop = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 19) == 0) run = ~run;
        stop       = ($urandom_range(0, 99) == 0);
        reset      = ($urandom_range(0, 399) == 0);
        wr_en      = ($urandom_range(0, 9) == 0);
        wr_ch      = CHW'($urandom_range(0, 3));
        wr_pattern = STEPS'($urandom);
        tg_en      = ($urandom_range(0, 5) == 0);
        tg_ch      = CHW'($urandom_range(0, 3));
        tg_step    = STW'($urandom_range(0, 3));
        rd_ch      = CHW'($urandom_range(0, 3));
        if ($urandom_range(0, 49) == 0) tempo_div = TW'($urandom_range(0, 6));
        step_cyc();
      end
      reset = 1'b0; wr_en = 1'b0; tg_en = 1'b0; stop = 1'b0;
    end

    idle(2);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
